upstream_adp: RTL

UPSTREAM_ADP -- requirements
Module: upstream_adp

---
 rtl/upstream_adp.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/upstream_adp.sv
// Streams one event from the event buffer onto AXI-stream: header read, then
// payload words 1..N through a 2-entry first-word-fall-through prefetch FIFO.
module upstream_adp (
  input  logic         clk,
  input  logic         ARESETn,
  input  logic         ev_ready,
  output logic         rd_en,
  output logic [9:0]   rd_addr,
  input  logic [127:0] rd_data,
  output logic         ev_done,
  output logic         err_empty,
  output logic         TVALID,
  input  logic         TREADY,
  output logic [127:0] TDATA,
  output logic [15:0]  TSTRB,
  output logic [15:0]  TKEEP,
  output logic         TLAST,
  output logic [10:0]  TID
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 11;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_RD  = 3'd1,
    HDR_CAP = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] n_q;
  logic          inflight;
  logic          inflight_last;
  logic          arriving;
  logic          arriving_last;
  logic [1:0]    cnt;
  logic [DW-1:0] mem0;
  logic [DW-1:0] mem1;
  logic          last0;
  logic          last1;

  logic          stored;
  logic          pop;
  logic          more;
  logic          can_issue;
  logic [2:0]    fill;
  logic [2:0]    slots;
  logic [AW-1:0] next_addr;

  assign TSTRB = {SW{1'b1}};
  assign TKEEP = {SW{1'b1}};

  // FIFO head is the oldest stored word, or the word returning this cycle when nothing is stored.
  always_comb begin
    stored    = (cnt != 2'd0);
    TVALID    = stored | arriving;
    TDATA     = '0;
    TLAST     = 1'b0;
    if (stored) begin
      TDATA = mem0;
      TLAST = last0;
    end else if (arriving) begin
      TDATA = rd_data;
      TLAST = arriving_last;
    end
    pop       = TVALID & TREADY;
    fill      = 3'(cnt) + 3'(arriving) - 3'(pop);
    slots     = fill + 3'(inflight);
    next_addr = rd_addr + 10'd1;
    more      = (rd_addr != n_q);
    can_issue = (state == DATA) && more && (slots < 3'd2);
  end

  // Control FSM; rd_en/rd_addr are registered so issue decisions look one cycle ahead.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      n_q           <= '0;
      TID           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      arriving      <= 1'b0;
      arriving_last <= 1'b0;
      ev_done       <= 1'b0;
      err_empty     <= 1'b0;
    end else begin
      rd_en         <= 1'b0;
      ev_done       <= 1'b0;
      err_empty     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      arriving      <= inflight;
      arriving_last <= inflight_last;
      case (state)
        IDLE: begin
          if (ev_ready) begin
            state   <= HDR_RD;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        HDR_RD: state <= HDR_CAP;
        HDR_CAP: begin
          n_q <= rd_data[AW-1:0];
          TID <= rd_data[AW +: BW];
          if (rd_data[AW-1:0] == '0) begin
            state     <= DONE;
            err_empty <= 1'b1;
            ev_done   <= 1'b1;
          end else begin
            state         <= DATA;
            rd_en         <= 1'b1;
            rd_addr       <= 10'd1;
            inflight      <= 1'b1;
            inflight_last <= (rd_data[AW-1:0] == 10'd1);
          end
        end
        DATA: begin
          if (can_issue) begin
            rd_en         <= 1'b1;
            rd_addr       <= next_addr;
            inflight      <= 1'b1;
            inflight_last <= (next_addr == n_q);
          end
          if (pop && TLAST) begin
            state   <= DONE;
            ev_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch storage: shift toward mem0 on pop; a returning word bypasses storage if popped at once.
  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt   <= '0;
      mem0  <= '0;
      mem1  <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      cnt <= fill[1:0];
      if (pop && stored) begin
        mem0  <= mem1;
        last0 <= last1;
        if (arriving) begin
          if (cnt == 2'd1) begin
            mem0  <= rd_data;
            last0 <= arriving_last;
          end else begin
            mem1  <= rd_data;
            last1 <= arriving_last;
          end
        end
      end else if (arriving && !pop) begin
        if (cnt == 2'd0) begin
          mem0  <= rd_data;
          last0 <= arriving_last;
        end else begin
          mem1  <= rd_data;
          last1 <= arriving_last;
        end
      end
    end
  end

endmodule
